// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, complex sample type, bank states, bit-reversal helper.
// Latency: n/a (types, constants and a pure combinational function only).
// Backpressure: n/a.
package fft_pkg;

  localparam int LOG2N  = 3;
  localparam int N      = 1 << LOG2N;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  // Reverses the low 'width' bits of idx (width <= 16); upper result bits are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int unsigned width);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[i] = idx[15-i];
    end
    return r >> (16 - width);
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N-entry {re, im} sample bank with a write port, a combinational read port and an EMPTY/FULL flag.
// Latency: write lands on the clock edge; read data is combinational from the read address.
// Backpressure: none here; the owner must only write while EMPTY and only read while FULL.
module fft_reorder_bank #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [LOG2N-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_re_i,
  input  logic [DATA_W-1:0] wr_im_i,
  input  logic              wr_last_i,
  input  logic [LOG2N-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_re_o,
  output logic [DATA_W-1:0] rd_im_o,
  input  logic              rd_done_i,
  output logic              full_o
);
  import fft_pkg::*;

  localparam int DEPTH = 1 << LOG2N;

  logic [DATA_W-1:0] re_q [DEPTH];
  logic [DATA_W-1:0] im_q [DEPTH];
  bank_state_t       state_q, state_d;

  // Flag turns FULL when the last sample of a frame lands, EMPTY when the last one is read out.
  always_comb begin
    state_d = state_q;
    if (wr_last_i) begin
      state_d = FULL;
    end else if (rd_done_i) begin
      state_d = EMPTY;
    end
  end

  // Flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample storage; cleared on reset so nothing stale can ever be presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      re_q[wr_addr_i] <= wr_re_i;
      im_q[wr_addr_i] <= wr_im_i;
    end
  end

  assign rd_re_o = re_q[rd_addr_i];
  assign rd_im_o = im_q[rd_addr_i];
  assign full_o  = (state_q == FULL);

endmodule

// File: rtl/fft_input_reorder.sv
// Ping-pong frame buffer: natural-order samples in, bit-reversed order out (optional stats: FFT_REORDER_STATS_EN).
// Latency: first output valid the cycle after the last sample of a frame is accepted; 1 sample/cycle, no frame gaps.
// Backpressure: in_ready drops only while both banks are FULL; outputs hold stable while out_valid && !out_ready.
module fft_input_reorder #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int LOG2N  = fft_pkg::LOG2N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]  out_idx,
`ifdef FFT_REORDER_STATS_EN
  output logic [15:0]       frame_cnt,
  output logic              overflow_seen,
`endif
  output logic              out_last
);
  import fft_pkg::*;

  localparam int                 DEPTH    = 1 << LOG2N;
  localparam logic [LOG2N-1:0]   LAST_PTR = LOG2N'(DEPTH - 1);

  logic              wr_bank_q, wr_bank_d;
  logic [LOG2N-1:0]  wr_ptr_q,  wr_ptr_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  rd_ptr_q,  rd_ptr_d;

  logic [1:0]        bank_full;
  logic [DATA_W-1:0] bank_re [2];
  logic [DATA_W-1:0] bank_im [2];
  logic [LOG2N-1:0]  rd_addr;
  logic              wr_fire;
  logic              rd_fire;

  assign in_ready  = !bank_full[wr_bank_q];
  assign out_valid =  bank_full[rd_bank_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Output slot k of the frame carries source sample bitrev(k).
  assign rd_addr   = LOG2N'(bitrev(16'(rd_ptr_q), LOG2N));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .DATA_W (DATA_W),
      .LOG2N  (LOG2N)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_fire && (wr_bank_q == 1'(b))),
      .wr_addr_i (wr_ptr_q),
      .wr_re_i   (in_re),
      .wr_im_i   (in_im),
      .wr_last_i (wr_fire && (wr_bank_q == 1'(b)) && (wr_ptr_q == LAST_PTR)),
      .rd_addr_i (rd_addr),
      .rd_re_o   (bank_re[b]),
      .rd_im_o   (bank_im[b]),
      .rd_done_i (rd_fire && (rd_bank_q == 1'(b)) && (rd_ptr_q == LAST_PTR)),
      .full_o    (bank_full[b])
    );
  end

  // Writer and reader pointers advance independently; each flips its bank on frame wrap.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    rd_bank_d = rd_bank_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == LAST_PTR) begin
        wr_bank_d = !wr_bank_q;
      end
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (rd_ptr_q == LAST_PTR) begin
        rd_bank_d = !rd_bank_q;
      end
    end
  end

  // Pointer and bank-select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_ptr_q  <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_bank_q <= rd_bank_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign out_re   = bank_re[rd_bank_q];
  assign out_im   = bank_im[rd_bank_q];
  assign out_idx  = rd_ptr_q;
  assign out_last = out_valid && (rd_ptr_q == LAST_PTR);

`ifdef FFT_REORDER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic        overflow_q;

  // Completed-frame counter (wraps naturally) and sticky flag for pushes into a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (rd_fire && out_last) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign frame_cnt     = frame_cnt_q;
  assign overflow_seen = overflow_q;
`endif

endmodule

// File: tb/tb_fft_input_reorder.sv
// Directed bench for fft_input_reorder: ordering, frame streaming, backpressure, stalls, reset, optional stats.
// Latency: inputs driven 1ns after posedge; outputs sampled on negedge.
// Backpressure: exercised by holding out_ready low and by toggled stall patterns.
module tb_fft_input_reorder;

  localparam int DW = 16;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [LW-1:0] out_idx;
  logic          out_last;
`ifdef FFT_REORDER_STATS_EN
  logic [15:0]   frame_cnt;
  logic          overflow_seen;
`endif

  fft_input_reorder #(.DATA_W(DW), .LOG2N(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
`ifdef FFT_REORDER_STATS_EN
    .frame_cnt     (frame_cnt),
    .overflow_seen (overflow_seen),
`endif
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int idx;
    int last;
    int cyc;
  } obs_t;

  obs_t q[$];
  obs_t mon_o;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   stalls = 0;
  int   BR[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer that will occur at the coming posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_o.re   = int'(out_re);
      mon_o.im   = int'(out_im);
      mon_o.idx  = int'(out_idx);
      mon_o.last = int'(out_last);
      mon_o.cyc  = cyc;
      q.push_back(mon_o);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample and hold it until accepted; returns at posedge+1.
  task automatic push(input int v);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_re = DW'(v);
    in_im = DW'(v + 100);
    while (t < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) check($sformatf("push %0d timeout", v), 0, 1);
  endtask

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) push(first + i);
  endtask

  task automatic wait_out(input int n, input string tag);
    int t;
    t = 0;
    while (q.size() < n && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    check({tag, " count"}, q.size(), n);
  endtask

  task automatic check_frames(input int base, input int nf, input string tag);
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < 8; k++) begin
        int i;
        int e;
        i = f * 8 + k;
        e = base + f * 8 + BR[k];
        if (i < q.size()) begin
          check($sformatf("%s re[%0d]", tag, i), q[i].re, e);
          check($sformatf("%s im[%0d]", tag, i), q[i].im, e + 100);
          check($sformatf("%s idx[%0d]", tag, i), q[i].idx, k);
          check($sformatf("%s last[%0d]", tag, i), q[i].last, (k == 7) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[5]    = '{1, 0, 0, 1, 1};
    int exps[5]   = '{0, 4, 4, 4, 2};
    int expidx[5] = '{0, 1, 1, 1, 2};
    int j;

    rst = 1'b1;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst out_idx", out_idx, 0);
    check("rst out_re", out_re, 0);
    check("rst out_im", out_im, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame, first-output latency.
    q.delete();
    out_ready = 1'b1;
    push_range(0, 8);
    @(negedge clk);
    check("t1 latency out_valid", out_valid, 1);
    check("t1 latency out_idx", out_idx, 0);
    check("t1 latency out_re", out_re, 0);
    wait_out(8, "t1");
    check_frames(0, 1, "t1");

    // Back-to-back frames with no bubbles.
    q.delete();
    stalls = 0;
    push_range(0, 16);
    wait_out(16, "t2");
    check_frames(0, 2, "t2");
    check("t2 input stalls", stalls, 0);
    begin
      int gaps;
      gaps = 0;
      for (int i = 1; i < q.size(); i++) if (q[i].cyc - q[i-1].cyc != 1) gaps++;
      check("t2 output gaps", gaps, 0);
    end

    // Full backpressure: two frames fill both banks, 17th waits.
    q.delete();
    out_ready = 1'b0;
    stalls = 0;
    push_range(30, 16);
    check("t3 stalls while filling", stalls, 0);
    in_valid = 1'b1;
    in_re = DW'(46);
    in_im = DW'(146);
    @(negedge clk);
    check("t3 in_ready both full", in_ready, 0);
    check("t3 out_valid both full", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    j = 0;
    while (j < 50) begin
      @(negedge clk);
      j++;
      if (in_ready) break;
    end
    check("t3 cycles until 17th accepted", j, 9);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_range(47, 7);
    wait_out(24, "t3");
    check_frames(30, 3, "t3");

    // Stalled output stability with out_ready pattern 1,0,0,1.
    q.delete();
    out_ready = 1'b0;
    push_range(0, 8);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      out_ready = pat[c][0];
      @(negedge clk);
      check($sformatf("t4 stall re c%0d", c), out_re, exps[c]);
      check($sformatf("t4 stall idx c%0d", c), out_idx, expidx[c]);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_out(8, "t4");
    check_frames(0, 1, "t4");

    // Reset mid-frame discards partial data.
    out_ready = 1'b1;
    push_range(90, 3);
    rst = 1'b1;
    @(negedge clk);
    check("t5 rst in_ready", in_ready, 1);
    check("t5 rst out_valid", out_valid, 0);
    check("t5 rst out_re", out_re, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    push_range(20, 8);
    wait_out(8, "t5");
    check_frames(20, 1, "t5");

`ifdef FFT_REORDER_STATS_EN
    // Frame counter and sticky overflow flag.
    q.delete();
    push_range(0, 16);
    wait_out(16, "t6");
    check("t6 frame_cnt", frame_cnt, 3);
    check("t6 overflow before", overflow_seen, 0);
    out_ready = 1'b0;
    push_range(0, 16);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t6 overflow set", overflow_seen, 1);
    q.delete();
    out_ready = 1'b1;
    wait_out(16, "t6 drain");
    check("t6 overflow sticky", overflow_seen, 1);
    check("t6 frame_cnt after drain", frame_cnt, 5);
    pulse_reset();
    @(negedge clk);
    check("t6 overflow cleared", overflow_seen, 0);
    check("t6 frame_cnt cleared", frame_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
